// File: rtl/result_pipe_pkg.sv
// Shared types for the result pipeline: spec-register selects and the per-stage record
// carried through EX/MEM and MEM/WB.
package result_pipe_pkg;

  localparam int PKG_DATA_W = 16;
  localparam int PKG_REG_AW = 3;
  localparam int PKG_CNT_W  = 16;

  localparam logic [1:0] SPEC_GPR = 2'b00;
  localparam logic [1:0] SPEC_T   = 2'b01;
  localparam logic [1:0] SPEC_SP  = 2'b10;
  localparam logic [1:0] SPEC_IH  = 2'b11;

  typedef struct packed {
    logic                  reg_write;
    logic [PKG_REG_AW-1:0] id;
    logic [1:0]            spec_reg;
    logic                  mem_read;
    logic [PKG_DATA_W-1:0] data;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

  function automatic logic targets_spec(input logic [1:0] spec_reg);
    return spec_reg != SPEC_GPR;
  endfunction

endpackage

// File: rtl/result_pipe_stage_reg.sv
// One pipeline register holding a stage record; bubble wins over hold so a flush
// arriving during a stall is never lost.
module result_pipe_stage_reg
  import result_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  stage_rec_t stage_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= STAGE_BUBBLE;
    end else if (bubble) begin
      stage_reg <= STAGE_BUBBLE;
    end else if (!hold) begin
      stage_reg <= d;
    end
  end

  assign q = stage_reg;

endmodule

// File: rtl/result_pipe.sv
// EX/MEM and MEM/WB result registers feeding the forwarding unit and the register-file
// write port, with a load flag for the hazard unit and a retired-write counter.
module result_pipe
  import result_pipe_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int REG_AW = PKG_REG_AW,
  parameter int CNT_W  = PKG_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite_a_IDEX,
  input  logic [REG_AW-1:0] registerToWriteId_a_IDEX,
  input  logic [1:0]        writeSpecReg_a_IDEX,
  input  logic              memRead_a_IDEX,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] memReadData,
  input  logic              stall,
  input  logic              flush,
  output logic              regWrite_a_EXMEM,
  output logic [REG_AW-1:0] registerToWriteId_a_EXMEM,
  output logic [1:0]        writeSpecReg_a_EXMEM,
  output logic [DATA_W-1:0] data_EXMEM,
  output logic              loadPending_EXMEM,
  output logic              regWrite_a_MEMWB,
  output logic [REG_AW-1:0] registerToWriteId_a_MEMWB,
  output logic [1:0]        writeSpecReg_a_MEMWB,
  output logic [DATA_W-1:0] data_MEMWB,
  output logic              rfWriteEn,
  output logic              specWriteEn,
  output logic [REG_AW-1:0] rfWriteAddr,
  output logic [DATA_W-1:0] rfWriteData,
  output logic [CNT_W-1:0]  retireCount
);

  stage_rec_t ex_mem_next;
  stage_rec_t ex_mem_reg;
  stage_rec_t mem_wb_next;
  stage_rec_t mem_wb_reg;
  logic [CNT_W-1:0] retire_count_reg;
  logic             retire_next;

  always_comb begin
    ex_mem_next           = STAGE_BUBBLE;
    ex_mem_next.reg_write = regWrite_a_IDEX;
    ex_mem_next.id        = registerToWriteId_a_IDEX;
    ex_mem_next.spec_reg  = writeSpecReg_a_IDEX;
    ex_mem_next.mem_read  = memRead_a_IDEX;
    ex_mem_next.data      = aluResult;
  end

  // Loads pick up memory data on the way out of MEM; everything else keeps the ALU result.
  always_comb begin
    mem_wb_next = ex_mem_reg;
    if (ex_mem_reg.mem_read) begin
      mem_wb_next.data = memReadData;
    end
  end

  result_pipe_stage_reg u_ex_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall),
    .bubble (flush),
    .d      (ex_mem_next),
    .q      (ex_mem_reg)
  );

  result_pipe_stage_reg u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall),
    .bubble (1'b0),
    .d      (mem_wb_next),
    .q      (mem_wb_reg)
  );

  assign regWrite_a_EXMEM          = ex_mem_reg.reg_write;
  assign registerToWriteId_a_EXMEM = ex_mem_reg.id;
  assign writeSpecReg_a_EXMEM      = ex_mem_reg.spec_reg;
  assign data_EXMEM                = ex_mem_reg.data;
  assign loadPending_EXMEM         = ex_mem_reg.mem_read;

  assign regWrite_a_MEMWB          = mem_wb_reg.reg_write;
  assign registerToWriteId_a_MEMWB = mem_wb_reg.id;
  assign writeSpecReg_a_MEMWB      = mem_wb_reg.spec_reg;
  assign data_MEMWB                = mem_wb_reg.data;

  // Gating with stall means a held MEM/WB entry strobes the file exactly once, on release.
  assign rfWriteEn   = mem_wb_reg.reg_write & ~targets_spec(mem_wb_reg.spec_reg) & ~stall;
  assign specWriteEn = mem_wb_reg.reg_write &  targets_spec(mem_wb_reg.spec_reg) & ~stall;
  assign rfWriteAddr = mem_wb_reg.id;
  assign rfWriteData = mem_wb_reg.data;
  assign retire_next = rfWriteEn | specWriteEn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_count_reg <= '0;
    end else if (retire_next) begin
      retire_count_reg <= retire_count_reg + CNT_W'(1);
    end
  end

  assign retireCount = retire_count_reg;

endmodule
